header_stream: RTL and testbench

HEADER_STREAM -- requirements
Module: header_stream

---
 rtl/header_stream.sv | 138 +++++++++++++
 tb/tb_header_stream.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/header_stream.sv
// Accumulates BEATS_PER_BLOCK beats of pixels and emits one header per block:
// per-channel min/max, residual bit width, constant-channel flags and a compressable flag.
module header_stream #(
  parameter int NUM_CH          = 4,
  parameter int CH_W            = 8,
  parameter int PIX_PER_BEAT    = 8,
  parameter int BEATS_PER_BLOCK = 4,
  parameter int MAX_RES_W       = 4,
  localparam int RW             = $clog2(CH_W + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [PIX_PER_BEAT*NUM_CH*CH_W-1:0]  in_pixels,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NUM_CH*CH_W-1:0]               out_min,
  output logic [NUM_CH*CH_W-1:0]               out_max,
  output logic [NUM_CH*RW-1:0]                 out_res_w,
  output logic [NUM_CH-1:0]                    out_skip,
  output logic                                 out_compressable,
  output logic                                 fsm_state
);

  // Handshakes: a beat transfers on a rising edge where in_valid && in_ready,
  // a header transfers where out_valid && out_ready; clear overrides both.
  localparam int CW = (BEATS_PER_BLOCK > 1) ? $clog2(BEATS_PER_BLOCK) : 1;
  localparam logic ACCUM = 1'b0;
  localparam logic EMIT  = 1'b1;

  logic          state;
  logic [CW-1:0] count;
  logic [CH_W-1:0] run_min  [NUM_CH];
  logic [CH_W-1:0] run_max  [NUM_CH];
  logic [CH_W-1:0] beat_min [NUM_CH];
  logic [CH_W-1:0] beat_max [NUM_CH];
  logic [CH_W-1:0] next_min [NUM_CH];
  logic [CH_W-1:0] next_max [NUM_CH];
  logic [RW-1:0]   res_w    [NUM_CH];
  logic            all_fit;
  logic            accept;
  logic            last_beat;

  // Bit length of the range: 0 for 0, else floor(log2(d))+1.
  function automatic logic [RW-1:0] bit_len(input logic [CH_W-1:0] d);
    logic [RW-1:0] n;
    n = '0;
    for (int i = 0; i < CH_W; i++) begin
      if (d[i]) n = RW'(i + 1);
    end
    return n;
  endfunction

  assign in_ready  = (state == ACCUM) && !rst;
  assign out_valid = (state == EMIT);
  assign fsm_state = state;
  assign accept    = in_valid && in_ready;
  assign last_beat = (count == CW'(BEATS_PER_BLOCK - 1));

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      beat_min[c] = in_pixels[c*CH_W +: CH_W];
      beat_max[c] = in_pixels[c*CH_W +: CH_W];
      for (int p = 1; p < PIX_PER_BEAT; p++) begin
        if (in_pixels[(p*NUM_CH+c)*CH_W +: CH_W] < beat_min[c])
          beat_min[c] = in_pixels[(p*NUM_CH+c)*CH_W +: CH_W];
        if (in_pixels[(p*NUM_CH+c)*CH_W +: CH_W] > beat_max[c])
          beat_max[c] = in_pixels[(p*NUM_CH+c)*CH_W +: CH_W];
      end
    end
  end

  // The first beat of a block replaces the running values instead of merging.
  always_comb begin
    all_fit = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (count == '0) begin
        next_min[c] = beat_min[c];
        next_max[c] = beat_max[c];
      end else begin
        next_min[c] = (beat_min[c] < run_min[c]) ? beat_min[c] : run_min[c];
        next_max[c] = (beat_max[c] > run_max[c]) ? beat_max[c] : run_max[c];
      end
      res_w[c] = bit_len(next_max[c] - next_min[c]);
      if (int'(res_w[c]) > MAX_RES_W) all_fit = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ACCUM;
      count            <= '0;
      out_min          <= '0;
      out_max          <= '0;
      out_res_w        <= '0;
      out_skip         <= '0;
      out_compressable <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        run_min[c] <= '0;
        run_max[c] <= '0;
      end
    end else if (clear) begin
      state <= ACCUM;
      count <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            for (int c = 0; c < NUM_CH; c++) begin
              run_min[c] <= next_min[c];
              run_max[c] <= next_max[c];
            end
            if (last_beat) begin
              count <= '0;
              state <= EMIT;
              for (int c = 0; c < NUM_CH; c++) begin
                out_min[c*CH_W +: CH_W] <= next_min[c];
                out_max[c*CH_W +: CH_W] <= next_max[c];
                out_res_w[c*RW +: RW]   <= res_w[c];
                out_skip[c]             <= (res_w[c] == '0);
              end
              out_compressable <= all_fit;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_header_stream.sv
// Bench for header_stream: directed block patterns plus randomized traffic,
// scored against a block-level reference model.
module tb_header_stream;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 8;
  localparam int PPB    = 8;
  localparam int BPB    = 4;
  localparam int MAXRW  = 4;
  localparam int BW     = PPB * NUM_CH * CH_W;
  localparam int RW     = $clog2(CH_W + 1);
  localparam int HW     = 2*NUM_CH*CH_W + NUM_CH*RW + NUM_CH + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   clear = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [BW-1:0]          in_pixels = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [NUM_CH*CH_W-1:0] out_min;
  logic [NUM_CH*CH_W-1:0] out_max;
  logic [NUM_CH*RW-1:0]   out_res_w;
  logic [NUM_CH-1:0]      out_skip;
  logic                   out_compressable;
  logic                   fsm_state;
  logic [HW-1:0]          hdr_now;

  header_stream #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .PIX_PER_BEAT(PPB),
    .BEATS_PER_BLOCK(BPB), .MAX_RES_W(MAXRW)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixels(in_pixels),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max), .out_res_w(out_res_w),
    .out_skip(out_skip), .out_compressable(out_compressable),
    .fsm_state(fsm_state)
  );

  assign hdr_now = {out_min, out_max, out_res_w, out_skip, out_compressable};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model
  logic [BW-1:0] blk_q[$];
  logic [HW-1:0] exp_q[$];

  function automatic logic [HW-1:0] model_hdr();
    int mn[NUM_CH];
    int mx[NUM_CH];
    int v, d, w;
    logic [NUM_CH*CH_W-1:0] vmin, vmax;
    logic [NUM_CH*RW-1:0]   vrw;
    logic [NUM_CH-1:0]      vsk;
    logic                   comp;
    for (int c = 0; c < NUM_CH; c++) begin
      mn[c] = (1 << CH_W) - 1;
      mx[c] = 0;
    end
    foreach (blk_q[b])
      for (int p = 0; p < PPB; p++)
        for (int c = 0; c < NUM_CH; c++) begin
          v = int'(blk_q[b][(p*NUM_CH+c)*CH_W +: CH_W]);
          if (v < mn[c]) mn[c] = v;
          if (v > mx[c]) mx[c] = v;
        end
    comp = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      d = mx[c] - mn[c];
      w = 0;
      while (d > 0) begin
        w++;
        d = d / 2;
      end
      vmin[c*CH_W +: CH_W] = CH_W'(mn[c]);
      vmax[c*CH_W +: CH_W] = CH_W'(mx[c]);
      vrw[c*RW +: RW]      = RW'(w);
      vsk[c]               = (w == 0);
      if (w > MAXRW) comp = 1'b0;
    end
    return {vmin, vmax, vrw, vsk, comp};
  endfunction

  // scoreboard: inputs are stable at the falling edge, so this sees exactly
  // what the next rising edge will transfer
  always @(negedge clk) begin
    if (!rst) begin
      if (clear) begin
        if (out_valid && exp_q.size() > 0) exp_q.delete(0);
        blk_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("hdr_queue", exp_q.size(), 1);
          else begin
            check("header", hdr_now, exp_q[0]);
            exp_q.delete(0);
          end
        end
        if (in_valid && in_ready) begin
          blk_q.push_back(in_pixels);
          if (blk_q.size() == BPB) begin
            exp_q.push_back(model_hdr());
            blk_q.delete();
          end
        end
      end
    end
  end

  logic rand_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  int rb[NUM_CH];
  int rs[NUM_CH];

  task automatic new_random_block();
    int spreads[5] = '{0, 1, 7, 31, 255};
    for (int c = 0; c < NUM_CH; c++) begin
      rb[c] = $urandom_range(0, 255);
      rs[c] = spreads[$urandom_range(0, 4)];
    end
  endtask

  function automatic logic [BW-1:0] make_beat(input int b, input int kind);
    logic [BW-1:0] beat;
    int v;
    beat = '0;
    for (int p = 0; p < PPB; p++)
      for (int c = 0; c < NUM_CH; c++) begin
        case (kind)
          0: v = 'h40;
          1: v = (c == 0) ? b*PPB + p : 'h10;
          2: v = (c == 0) ? ((p % 2) ? 'hFF : 'h00) : 'h30 + (p % 8);
          3: v = 'h20 + b;
          default: begin
            v = rb[c] + $urandom_range(0, rs[c]);
            if (v > 255) v = 255;
          end
        endcase
        beat[(p*NUM_CH+c)*CH_W +: CH_W] = CH_W'(v);
      end
    return beat;
  endfunction

  function automatic logic [BW-1:0] junk();
    logic [BW-1:0] j;
    for (int i = 0; i < BW / 32; i++) j[i*32 +: 32] = $urandom;
    return j;
  endfunction

  // driver tasks: all start and end just after a rising edge
  task automatic drive_beat(input logic [BW-1:0] b, input int gap);
    logic rdy;
    logic done;
    done = 1'b0;
    in_valid  = 1'b1;
    in_pixels = b;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready && !clear;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    in_valid  = 1'b0;
    in_pixels = junk();
    check("beat_accept", done, 1);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_block(input int kind, input int gap);
    for (int b = 0; b < BPB; b++) drive_beat(make_beat(b, kind), gap);
  endtask

  task automatic wait_header();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("hdr_seen", seen, 1);
  endtask

  task automatic accept_header();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic check_fields(input logic [31:0] mn, input logic [31:0] mx,
                              input logic [15:0] rw, input logic [3:0] sk, input logic cp);
    check("min", out_min, mn);
    check("max", out_max, mx);
    check("res_w", out_res_w, rw);
    check("skip", out_skip, sk);
    check("compressable", out_compressable, cp);
  endtask

  logic [BW-1:0] saved[BPB];
  logic [HW-1:0] gap_ref;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_state", fsm_state, 0);
    check("rst_header", hdr_now, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    // constant block
    send_block(0, 0);
    wait_header();
    check_fields(32'h40404040, 32'h40404040, 16'h0000, 4'b1111, 1'b1);
    accept_header();
    @(negedge clk);
    check("post_hs_valid", out_valid, 0);
    check("post_hs_ready", in_ready, 1);
    check("post_hs_hold", hdr_now[0], 1);
    @(posedge clk);
    #1;

    // ramp on channel 0
    send_block(1, 0);
    wait_header();
    check_fields(32'h10101000, 32'h1010101F, 16'h0005, 4'b1110, 1'b0);
    accept_header();

    // full-range channel 0, range-8 others
    send_block(2, 1);
    wait_header();
    check_fields(32'h30303000, 32'h373737FF, 16'h3338, 4'b0000, 1'b0);
    accept_header();

    // back-pressure in EMIT with a beat offered
    new_random_block();
    send_block(4, 0);
    wait_header();
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_pixels = junk();
    repeat (3) begin
      @(negedge clk);
      check("stall_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_hold", hdr_now, exp_q.size() > 0 ? exp_q[0] : '0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    accept_header();
    new_random_block();
    send_block(4, 0);
    wait_header();
    accept_header();

    // reset mid-block
    new_random_block();
    drive_beat(make_beat(0, 4), 0);
    drive_beat(make_beat(1, 4), 0);
    rst = 1'b1;
    blk_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_block(3, 0);
    wait_header();
    check_fields(32'h20202020, 32'h23232323, 16'h2222, 4'b0000, 1'b1);
    accept_header();

    // clear drops a pending header and a beat offered alongside it
    new_random_block();
    send_block(4, 0);
    wait_header();
    @(posedge clk);
    #1;
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_pixels = junk();
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clear_valid", out_valid, 0);
    check("clear_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // clear after 3 beats, then the same block with gaps
    new_random_block();
    for (int b = 0; b < BPB; b++) saved[b] = make_beat(b, 4);
    for (int b = 0; b < BPB; b++) drive_beat(saved[b], 0);
    wait_header();
    gap_ref = exp_q.size() > 0 ? exp_q[0] : '0;
    accept_header();
    for (int b = 0; b < 3; b++) drive_beat(saved[b], 0);
    pulse_clear();
    for (int b = 0; b < BPB; b++) drive_beat(saved[b], $urandom_range(1, 2));
    wait_header();
    check("gap_equal", hdr_now, gap_ref);
    accept_header();

    // randomized traffic
    rand_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      new_random_block();
      for (int b = 0; b < BPB; b++) begin
        if ($urandom_range(0, 14) == 0) pulse_clear();
        drive_beat(make_beat(b, 4), $urandom_range(0, 2));
      end
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    check("drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
